// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the IF stage of the 5-stage MIPS pipeline.
// Holds bus widths, stall encoding, the reset PC default, and the packed
// layouts of the branch bus (ID -> IF) and the IF -> ID bus.
package inst_fetch_unit_pkg;

    localparam int unsigned IF_TO_ID_WD = 33;
    localparam int unsigned BR_WD       = 33;
    localparam int unsigned StallBus    = 6;

    // Stall vector bit encoding; bit 0 = PC, bit 1 = IF/ID.
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // First fetch address is RESET_PC + 4 = 32'hBFC0_0000.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFBF_FFFC;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    // Word-aligned check for instruction fetch addresses.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if_hold_buf.sv
// Replay hold buffer for the IF -> ID instruction word.
// When the IF/ID register is stalled, the SRAM keeps re-reading a frozen
// address and its data may change; this buffer captures the first word seen
// during the stall and presents it until the stall releases.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   hold         - IF/ID stage is stalled this cycle
//   rdata        - raw SRAM read data
//   inst         - stall-stable instruction word
module inst_fetch_unit_if_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    logic [31:0] hold_inst;
    logic        hold_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst  <= 32'b0;
            hold_valid <= 1'b0;
        end else if (hold) begin
            // Only the first word of a stall is kept; later re-reads are ignored.
            if (!hold_valid) begin
                hold_inst  <= rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    assign inst = hold_valid ? hold_inst : rdata;

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline.
// Owns the PC register, issues instruction-SRAM reads, accepts redirects from
// ID via the branch bus, and forwards {ce, pc} plus a stall-stable
// instruction word to ID.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   stall              - per-stage stall vector (bit 0 PC, bit 1 IF/ID)
//   br_bus             - {br_e, br_addr} from ID
//   inst_sram_*        - instruction SRAM read port (write side tied off)
//   if_to_id_bus       - {ce, pc} to the ID pipeline register
//   if_inst            - instruction for the PC held in ID's register
//   if_adel            - fetch address misaligned
//   perf_fetch_cnt     - accepted fetches
//   perf_redirect_cnt  - accepted redirects
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    input  logic [31:0]            inst_sram_rdata,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            if_inst,
    output logic                   if_adel,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_redirect_cnt
);

    br_bus_t     br;
    if_to_id_t   to_id;
    logic [31:0] pc_reg;
    logic        ce_reg;
    logic [31:0] next_pc;
    logic        pc_advance;
    logic        fetch_fire;
    logic        redirect_fire;

    // Upper stall bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^stall[StallBus-1:2];

    assign br = br_bus;

    // Branch target wins; sequential increment wraps silently at 2^32.
    assign next_pc    = br.br_e ? br.br_addr : pc_reg + 32'd4;
    assign pc_advance = (stall[0] == NoStop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
            ce_reg <= 1'b0;
        end else if (pc_advance) begin
            pc_reg <= next_pc;
            ce_reg <= 1'b1;
        end
    end

    // A misaligned PC still flows downstream with ce set so ID can trap it.
    assign if_adel = ce_reg & pc_misaligned(pc_reg);

    assign inst_sram_en    = ce_reg & ~if_adel;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'b0;

    assign to_id.ce     = ce_reg;
    assign to_id.pc     = pc_reg;
    assign if_to_id_bus = to_id;

    assign fetch_fire    = pc_advance & ce_reg & ~if_adel;
    assign redirect_fire = pc_advance & br.br_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'b0;
            perf_redirect_cnt <= 32'b0;
        end else begin
            if (fetch_fire) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_fire) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end

    inst_fetch_unit_if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall[1] == Stop),
        .rdata (inst_sram_rdata),
        .inst  (if_inst)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, sequential fetch, redirect,
// replay hold, stalled branch, misaligned fetch, PC wrap, reset during hold.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;
    logic        if_adel;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;

    int checks;
    int failures;

    localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

    inst_fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .br_bus            (br_bus),
        .inst_sram_rdata   (inst_sram_rdata),
        .inst_sram_en      (inst_sram_en),
        .inst_sram_wen     (inst_sram_wen),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .if_to_id_bus      (if_to_id_bus),
        .if_inst           (if_inst),
        .if_adel           (if_adel),
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stall  = 6'b0;
        br_bus = 33'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        inst_sram_rdata = 32'hDEAD_BEEF;
        do_reset();
        checks++; if (inst_sram_en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", inst_sram_en); end
        checks++; if (if_to_id_bus !== {1'b0, RST_PC}) begin failures++; $display("FAIL rst_bus got=%h exp=%h", if_to_id_bus, {1'b0, RST_PC}); end
        checks++; if (if_adel !== 1'b0) begin failures++; $display("FAIL rst_adel got=%b exp=0", if_adel); end
        checks++; if (perf_fetch_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_redirect_cnt); end
        checks++; if (if_inst !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rst_inst got=%h exp=deadbeef", if_inst); end
        checks++; if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin failures++; $display("FAIL rst_wr got=%h/%h exp=0/0", inst_sram_wen, inst_sram_wdata); end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_cnt  [4];
        exp_addr = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C};
        exp_cnt  = '{32'd0, 32'd1, 32'd2, 32'd3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (inst_sram_addr !== exp_addr[i]) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, inst_sram_addr, exp_addr[i]); end
            checks++; if (perf_fetch_cnt !== exp_cnt[i]) begin failures++; $display("FAIL seq_cnt%0d got=%0d exp=%0d", i, perf_fetch_cnt, exp_cnt[i]); end
        end
        checks++; if (inst_sram_en !== 1'b1 || if_to_id_bus !== {1'b1, 32'hBFC0_000C}) begin failures++; $display("FAIL seq_bus got=%b/%h exp=1/%h", inst_sram_en, if_to_id_bus, {1'b1, 32'hBFC0_000C}); end
    endtask

    task automatic test_branch();
        do_reset();
        step();
        step();
        br_bus = {1'b1, 32'hBFC0_0100};
        step();
        br_bus = 33'b0;
        checks++; if (inst_sram_addr !== 32'hBFC0_0100) begin failures++; $display("FAIL br_addr got=%h exp=bfc00100", inst_sram_addr); end
        checks++; if (perf_redirect_cnt !== 32'd1) begin failures++; $display("FAIL br_cnt got=%0d exp=1", perf_redirect_cnt); end
        step();
        checks++; if (inst_sram_addr !== 32'hBFC0_0104) begin failures++; $display("FAIL br_next got=%h exp=bfc00104", inst_sram_addr); end
    endtask

    task automatic test_stall_hold();
        logic [31:0] words [3];
        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        do_reset();
        step();
        step();
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            inst_sram_rdata = words[i];
            step();
            checks++; if (if_inst !== 32'h1111_1111) begin failures++; $display("FAIL hold_inst%0d got=%h exp=11111111", i, if_inst); end
            checks++; if (inst_sram_addr !== 32'hBFC0_0004) begin failures++; $display("FAIL hold_addr%0d got=%h exp=bfc00004", i, inst_sram_addr); end
        end
        stall = 6'b0;
        inst_sram_rdata = 32'h4444_4444;
        step();
        checks++; if (if_inst !== 32'h4444_4444) begin failures++; $display("FAIL hold_release got=%h exp=44444444", if_inst); end
        checks++; if (inst_sram_addr !== 32'hBFC0_0008 || perf_fetch_cnt !== 32'd2) begin failures++; $display("FAIL hold_resume got=%h/%0d exp=bfc00008/2", inst_sram_addr, perf_fetch_cnt); end
    endtask

    task automatic test_stall_branch();
        do_reset();
        step();
        step();
        stall  = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        step();
        checks++; if (inst_sram_addr !== 32'hBFC0_0004 || perf_redirect_cnt !== 32'd0) begin failures++; $display("FAIL stbr_hold got=%h/%0d exp=bfc00004/0", inst_sram_addr, perf_redirect_cnt); end
        stall  = 6'b0;
        br_bus = 33'b0;
        step();
        checks++; if (inst_sram_addr !== 32'hBFC0_0008 || perf_redirect_cnt !== 32'd0) begin failures++; $display("FAIL stbr_next got=%h/%0d exp=bfc00008/0", inst_sram_addr, perf_redirect_cnt); end
    endtask

    task automatic test_adel();
        do_reset();
        step();
        br_bus = {1'b1, 32'hBFC0_0102};
        step();
        br_bus = 33'b0;
        checks++; if (if_adel !== 1'b1 || inst_sram_en !== 1'b0) begin failures++; $display("FAIL adel_flag got=%b/%b exp=1/0", if_adel, inst_sram_en); end
        checks++; if (if_to_id_bus !== {1'b1, 32'hBFC0_0102}) begin failures++; $display("FAIL adel_bus got=%h exp=%h", if_to_id_bus, {1'b1, 32'hBFC0_0102}); end
        checks++; if (perf_fetch_cnt !== 32'd1) begin failures++; $display("FAIL adel_cnt0 got=%0d exp=1", perf_fetch_cnt); end
        step();
        checks++; if (inst_sram_addr !== 32'hBFC0_0106 || perf_fetch_cnt !== 32'd1) begin failures++; $display("FAIL adel_next got=%h/%0d exp=bfc00106/1", inst_sram_addr, perf_fetch_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        br_bus = {1'b1, 32'hFFFF_FFFC};
        step();
        br_bus = 33'b0;
        step();
        checks++; if (inst_sram_addr !== 32'h0000_0000 || if_adel !== 1'b0) begin failures++; $display("FAIL wrap got=%h/%b exp=00000000/0", inst_sram_addr, if_adel); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        step();
        step();
        stall = 6'b000111;
        inst_sram_rdata = 32'hAAAA_AAAA;
        step();
        inst_sram_rdata = 32'hBBBB_BBBB;
        checks++; if (if_inst !== 32'hAAAA_AAAA) begin failures++; $display("FAIL rsth_pre got=%h exp=aaaaaaaa", if_inst); end
        rst = 1'b1;
        step();
        checks++; if (if_inst !== 32'hBBBB_BBBB) begin failures++; $display("FAIL rsth_inst got=%h exp=bbbbbbbb", if_inst); end
        checks++; if (if_to_id_bus !== {1'b0, RST_PC} || inst_sram_en !== 1'b0) begin failures++; $display("FAIL rsth_bus got=%h/%b exp=%h/0", if_to_id_bus, inst_sram_en, {1'b0, RST_PC}); end
        rst   = 1'b0;
        stall = 6'b0;
        step();
        checks++; if (if_to_id_bus !== {1'b1, 32'hBFC0_0000}) begin failures++; $display("FAIL rsth_fetch got=%h exp=%h", if_to_id_bus, {1'b1, 32'hBFC0_0000}); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        stall           = 6'b0;
        br_bus          = 33'b0;
        inst_sram_rdata = 32'b0;
        test_reset();
        test_seq_fetch();
        test_branch();
        test_stall_hold();
        test_stall_branch();
        test_adel();
        test_wrap();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
